// File: rtl/square_move_ctrl.sv
// square_move_ctrl: debounced-button movement scheduler issuing per-frame move bursts during vblank
//   clk, rst                            clock, synchronous active-high reset
//   btn_left/right/up/down              raw asynchronous push-buttons, active-high
//   h_count[9:0], v_count[8:0]          VGA beam position, used to find the frame event
//   left/right/up/down                  one-pixel-per-cycle move strobes to the sprite
module square_move_ctrl #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int REPEAT_DELAY    = 15,
    parameter int ACCEL_FRAMES    = 8,
    parameter int MAX_STEP        = 4,
    parameter int V_ACTIVE        = 480
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic [9:0] h_count,
    input  logic [8:0] v_count,
    output logic       left,
    output logic       right,
    output logic       up,
    output logic       down
);
    localparam logic [1:0] IDLE = 2'd0, HOLD = 2'd1, REPEAT = 2'd2;
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int FW = $clog2(REPEAT_DELAY + 1);
    localparam int AW = $clog2(ACCEL_FRAMES + 1);

    logic [3:0]    raw, s1, s2, db;
    logic [DW-1:0] dcnt [4];
    logic          cond, cond_q, frame;
    logic [1:0]    pos, act;
    logic [1:0]    st [2];
    logic [1:0]    sdir, bdir;
    logic [FW-1:0] fcnt [2];
    logic [AW-1:0] acc [2];
    logic [3:0]    step [2];
    logic [3:0]    bcnt [2];

    assign raw  = {btn_down, btn_up, btn_right, btn_left};
    assign cond = (v_count == 9'(V_ACTIVE)) && (h_count == '0);
    // index 0 is the x axis (right positive), index 1 the y axis (down positive)
    assign pos  = {db[3], db[1]};
    assign act  = {db[3] ^ db[2], db[1] ^ db[0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            s1     <= '0;
            s2     <= '0;
            cond_q <= 1'b0;
            frame  <= 1'b0;
        end else begin
            s1     <= raw;
            s2     <= s1;
            cond_q <= cond;
            frame  <= cond && !cond_q;
        end
    end

    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (rst) begin
                dcnt[b] <= '0;
                db[b]   <= 1'b0;
            end else if (s2[b] == db[b]) begin
                dcnt[b] <= '0;
            end else if (dcnt[b] == DW'(DEBOUNCE_CYCLES - 1)) begin
                dcnt[b] <= '0;
                db[b]   <= s2[b];
            end else begin
                dcnt[b] <= dcnt[b] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int a = 0; a < 2; a++) begin
            if (rst) begin
                st[a]   <= IDLE;
                sdir[a] <= 1'b0;
                fcnt[a] <= '0;
                acc[a]  <= '0;
                step[a] <= 4'd1;
                bcnt[a] <= '0;
                bdir[a] <= 1'b0;
            end else if (frame) begin
                // every frame event restarts the burst; frames without a move leave it empty
                bcnt[a] <= '0;
                if (!act[a]) begin
                    st[a] <= IDLE;
                end else if (st[a] == IDLE || pos[a] != sdir[a]) begin
                    st[a]   <= HOLD;
                    sdir[a] <= pos[a];
                    fcnt[a] <= '0;
                    bcnt[a] <= 4'd1;
                    bdir[a] <= pos[a];
                end else if (st[a] == HOLD) begin
                    fcnt[a] <= fcnt[a] + 1'b1;
                    if (fcnt[a] == FW'(REPEAT_DELAY - 1)) begin
                        st[a]   <= REPEAT;
                        step[a] <= 4'd1;
                        acc[a]  <= '0;
                    end
                end else begin
                    bcnt[a] <= step[a];
                    bdir[a] <= sdir[a];
                    if (acc[a] == AW'(ACCEL_FRAMES - 1)) begin
                        acc[a]  <= '0;
                        step[a] <= (step[a] == 4'(MAX_STEP)) ? step[a] : step[a] + 4'd1;
                    end else begin
                        acc[a] <= acc[a] + 1'b1;
                    end
                end
            end else if (bcnt[a] != '0) begin
                bcnt[a] <= bcnt[a] - 4'd1;
            end
        end
    end

    assign right = (bcnt[0] != '0) && bdir[0];
    assign left  = (bcnt[0] != '0) && !bdir[0];
    assign down  = (bcnt[1] != '0) && bdir[1];
    assign up    = (bcnt[1] != '0) && !bdir[1];
endmodule
